// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with registered read addresses,
// write-through forwarding, a second "late" write port for long-latency
// results, and a per-register busy scoreboard for hazard reporting.
//
// Ports:
//   clock       rising-edge clock
//   rst         synchronous reset, active-high
//   pause       pipeline freeze (holds main write stage and read addresses)
//   rd_clk_cls  hold read addresses without freezing the write path
//   rd_addr     NRD packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data     NRD packed read data, port i at [i*DATA_W +: DATA_W]
//   rd_busy     per port: addressed register reserved and data not available
//   wr_*        main write port (captured into stage M)
//   lw_*        late write port (captured into stage L, never frozen)
//   rsv_*       reserve a register for a pending late write
//   busy_any    OR of all busy bits
//   waw_err     sticky: main write committed to a busy register
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   pause,
    input  logic                   rd_clk_cls,
    input  logic [NRD*ADDR_W-1:0]  rd_addr,
    output logic [NRD*DATA_W-1:0]  rd_data,
    output logic [NRD-1:0]         rd_busy,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   lw_en,
    input  logic [ADDR_W-1:0]      lw_addr,
    input  logic [DATA_W-1:0]      lw_data,
    input  logic                   rsv_en,
    input  logic [ADDR_W-1:0]      rsv_addr,
    output logic                   busy_any,
    output logic                   waw_err
);

    localparam int DEPTH = 2 ** ADDR_W;

    // True when the address is the hard-wired zero register.
    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    logic [DATA_W-1:0] bank_q  [DEPTH];
    logic [DATA_W-1:0] bank_d  [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [ADDR_W-1:0] raddr_q [NRD];
    logic [ADDR_W-1:0] raddr_d [NRD];

    logic              m_vld_q,  m_vld_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              l_vld_q,  l_vld_d;
    logic [ADDR_W-1:0] l_addr_q, l_addr_d;
    logic [DATA_W-1:0] l_data_q, l_data_d;
    logic              waw_q,    waw_d;

    // Capture stages: M freezes with pause, L always advances.
    always_comb begin
        if (!pause) begin
            m_vld_d  = wr_en;
            m_addr_d = wr_addr;
            m_data_d = wr_data;
        end else begin
            m_vld_d  = m_vld_q;
            m_addr_d = m_addr_q;
            m_data_d = m_data_q;
        end
        l_vld_d  = lw_en;
        l_addr_d = lw_addr;
        l_data_d = lw_data;
    end

    // Read address registers, held on pause or rd_clk_cls.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            if (!pause && !rd_clk_cls) begin
                raddr_d[i] = rd_addr[i*ADDR_W +: ADDR_W];
            end else begin
                raddr_d[i] = raddr_q[i];
            end
        end
    end

    // Bank commit from the capture stages; M wins over L on the same address.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            if (is_zero(ADDR_W'(k))) begin
                bank_d[k] = '0;
            end else if (m_vld_q && (m_addr_q == ADDR_W'(k))) begin
                bank_d[k] = m_data_q;
            end else if (l_vld_q && (l_addr_q == ADDR_W'(k))) begin
                bank_d[k] = l_data_q;
            end else begin
                bank_d[k] = bank_q[k];
            end
        end
    end

    // Scoreboard: a new reservation beats the clear from an L commit.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            if (rsv_en && !pause && (rsv_addr == ADDR_W'(k)) && !is_zero(rsv_addr)) begin
                busy_d[k] = 1'b1;
            end else if (l_vld_q && (l_addr_q == ADDR_W'(k))) begin
                busy_d[k] = 1'b0;
            end else begin
                busy_d[k] = busy_q[k];
            end
        end
        // Busy is sampled before this cycle's update: the M commit races the reservation.
        if (m_vld_q && busy_q[m_addr_q]) begin
            waw_d = 1'b1;
        end else begin
            waw_d = waw_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                bank_q[k] <= '0;
            end
            for (int i = 0; i < NRD; i++) begin
                raddr_q[i] <= '0;
            end
            busy_q   <= '0;
            m_vld_q  <= 1'b0;
            m_addr_q <= '0;
            m_data_q <= '0;
            l_vld_q  <= 1'b0;
            l_addr_q <= '0;
            l_data_q <= '0;
            waw_q    <= 1'b0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                bank_q[k] <= bank_d[k];
            end
            for (int i = 0; i < NRD; i++) begin
                raddr_q[i] <= raddr_d[i];
            end
            busy_q   <= busy_d;
            m_vld_q  <= m_vld_d;
            m_addr_q <= m_addr_d;
            m_data_q <= m_data_d;
            l_vld_q  <= l_vld_d;
            l_addr_q <= l_addr_d;
            l_data_q <= l_data_d;
            waw_q    <= waw_d;
        end
    end

    // Read mux: zero register, then M forward, then L forward, then bank.
    // L-forwarded data counts as available, so it masks the busy bit.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            if (is_zero(raddr_q[i])) begin
                rd_data[i*DATA_W +: DATA_W] = '0;
            end else if (m_vld_q && (m_addr_q == raddr_q[i])) begin
                rd_data[i*DATA_W +: DATA_W] = m_data_q;
            end else if (l_vld_q && (l_addr_q == raddr_q[i])) begin
                rd_data[i*DATA_W +: DATA_W] = l_data_q;
            end else begin
                rd_data[i*DATA_W +: DATA_W] = bank_q[raddr_q[i]];
            end
            rd_busy[i] = busy_q[raddr_q[i]] & ~(l_vld_q && (l_addr_q == raddr_q[i]));
        end
    end

    assign busy_any = |busy_q;
    assign waw_err  = waw_q;

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        pause = 1'b0;
    logic        rd_clk_cls = 1'b0;
    logic [9:0]  rd_addr = '0;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        lw_en = 1'b0;
    logic [4:0]  lw_addr = '0;
    logic [31:0] lw_data = '0;
    logic        rsv_en = 1'b0;
    logic [4:0]  rsv_addr = '0;
    logic        busy_any, waw_err;

    // second configuration: 4 read ports, 16-bit data, 8 registers
    logic [11:0] rd_addr2 = '0;
    logic [63:0] rd_data2;
    logic [3:0]  rd_busy2;
    logic        wr_en2 = 1'b0;
    logic [2:0]  wr_addr2 = '0;
    logic [15:0] wr_data2 = '0;
    logic        lw_en2 = 1'b0;
    logic [2:0]  lw_addr2 = '0;
    logic [15:0] lw_data2 = '0;
    logic        rsv_en2 = 1'b0;
    logic [2:0]  rsv_addr2 = '0;
    logic        busy_any2, waw_err2;

    int checks = 0;
    int failures = 0;

    reg_file_sb dut (
        .clock(clock), .rst(rst), .pause(pause), .rd_clk_cls(rd_clk_cls),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .lw_en(lw_en), .lw_addr(lw_addr), .lw_data(lw_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy_any(busy_any), .waw_err(waw_err)
    );

    reg_file_sb #(.DATA_W(16), .ADDR_W(3), .NRD(4), .ZERO_REG(1)) dut2 (
        .clock(clock), .rst(rst), .pause(pause), .rd_clk_cls(rd_clk_cls),
        .rd_addr(rd_addr2), .rd_data(rd_data2), .rd_busy(rd_busy2),
        .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .lw_en(lw_en2), .lw_addr(lw_addr2), .lw_data(lw_data2),
        .rsv_en(rsv_en2), .rsv_addr(rsv_addr2),
        .busy_any(busy_any2), .waw_err(waw_err2)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick();
        rst = 1'b0; rd_addr = {5'd1, 5'd0};
        tick();
        checks++; if (rd_data !== 64'd0) begin failures++; $display("FAIL reset_data0 got=%h exp=0", rd_data); end
        checks++; if (rd_busy !== 2'b00) begin failures++; $display("FAIL reset_busy got=%b exp=00", rd_busy); end
        checks++; if (busy_any !== 1'b0) begin failures++; $display("FAIL reset_busy_any got=%b exp=0", busy_any); end
        checks++; if (waw_err !== 1'b0) begin failures++; $display("FAIL reset_waw got=%b exp=0", waw_err); end
        rd_addr = {5'd3, 5'd2};
        tick();
        checks++; if (rd_data !== 64'd0) begin failures++; $display("FAIL reset_data23 got=%h exp=0", rd_data); end
        // write interrupted by reset is lost
        wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h0000_0055;
        tick();
        wr_en = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; rd_addr = {5'd0, 5'd12};
        tick();
        checks++; if (rd_data[31:0] !== 32'd0) begin failures++; $display("FAIL reset_midwrite got=%h exp=0", rd_data[31:0]); end
    endtask

    task automatic test_main_write();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF; rd_addr = {5'd0, 5'd5};
        tick();
        checks++; if (rd_data[31:0] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL mwr_forward got=%h exp=deadbeef", rd_data[31:0]); end
        wr_en = 1'b0;
        tick(); tick();
        checks++; if (rd_data[31:0] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL mwr_bank got=%h exp=deadbeef", rd_data[31:0]); end
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h0000_1234; rd_addr = {5'd5, 5'd0};
        tick();
        checks++; if (rd_data[31:0] !== 32'd0) begin failures++; $display("FAIL mwr_zero_fwd got=%h exp=0", rd_data[31:0]); end
        wr_en = 1'b0;
        tick(); tick();
        checks++; if (rd_data !== {32'hDEAD_BEEF, 32'd0}) begin failures++; $display("FAIL mwr_zero_bank got=%h exp=deadbeef00000000", rd_data); end
    endtask

    task automatic test_pause_hold();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
        tick();
        wr_addr = 5'd7; wr_data = 32'h77;
        tick();
        wr_en = 1'b0; rd_addr = {5'd0, 5'd3};
        tick(); tick();
        checks++; if (rd_data[31:0] !== 32'h33) begin failures++; $display("FAIL pause_pre got=%h exp=33", rd_data[31:0]); end
        pause = 1'b1; rd_addr = {5'd0, 5'd7};
        tick(); tick();
        checks++; if (rd_data[31:0] !== 32'h33) begin failures++; $display("FAIL pause_addr_hold got=%h exp=33", rd_data[31:0]); end
        pause = 1'b0; rd_clk_cls = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hABC;
        tick();
        checks++; if (rd_data[31:0] !== 32'hABC) begin failures++; $display("FAIL cls_hold_wr got=%h exp=abc", rd_data[31:0]); end
        wr_en = 1'b0; rd_clk_cls = 1'b0;
        tick();
        checks++; if (rd_data[31:0] !== 32'h77) begin failures++; $display("FAIL cls_release got=%h exp=77", rd_data[31:0]); end
        // a write offered during pause is never captured
        pause = 1'b1; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h999;
        tick(); tick();
        pause = 1'b0; wr_en = 1'b0;
        tick(); tick();
        checks++; if (rd_data[31:0] !== 32'h77) begin failures++; $display("FAIL pause_wr_drop got=%h exp=77", rd_data[31:0]); end
    endtask

    task automatic test_scoreboard();
        rsv_en = 1'b1; rsv_addr = 5'd9; rd_addr = {5'd0, 5'd9};
        tick();
        rsv_en = 1'b0;
        checks++; if (rd_busy[0] !== 1'b1) begin failures++; $display("FAIL sb_busy_set got=%b exp=1", rd_busy[0]); end
        checks++; if (busy_any !== 1'b1) begin failures++; $display("FAIL sb_busy_any_set got=%b exp=1", busy_any); end
        lw_en = 1'b1; lw_addr = 5'd9; lw_data = 32'hCAFE;
        tick();
        lw_en = 1'b0;
        checks++; if (rd_busy[0] !== 1'b0) begin failures++; $display("FAIL sb_lfwd_busy got=%b exp=0", rd_busy[0]); end
        checks++; if (rd_data[31:0] !== 32'hCAFE) begin failures++; $display("FAIL sb_lfwd_data got=%h exp=cafe", rd_data[31:0]); end
        tick();
        checks++; if (busy_any !== 1'b0) begin failures++; $display("FAIL sb_cleared got=%b exp=0", busy_any); end
        checks++; if (rd_data[31:0] !== 32'hCAFE) begin failures++; $display("FAIL sb_bank got=%h exp=cafe", rd_data[31:0]); end
        pause = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd11;
        tick();
        pause = 1'b0; rsv_en = 1'b0;
        tick();
        checks++; if (busy_any !== 1'b0) begin failures++; $display("FAIL sb_pause_drop got=%b exp=0", busy_any); end
        checks++; if (waw_err !== 1'b0) begin failures++; $display("FAIL sb_no_err got=%b exp=0", waw_err); end
    endtask

    task automatic test_collision();
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h11;
        lw_en = 1'b1; lw_addr = 5'd4; lw_data = 32'h22; rd_addr = {5'd0, 5'd4};
        tick();
        wr_en = 1'b0; lw_en = 1'b0;
        checks++; if (rd_data[31:0] !== 32'h11) begin failures++; $display("FAIL coll_fwd got=%h exp=11", rd_data[31:0]); end
        tick(); tick();
        checks++; if (rd_data[31:0] !== 32'h11) begin failures++; $display("FAIL coll_bank got=%h exp=11", rd_data[31:0]); end
        rsv_en = 1'b1; rsv_addr = 5'd6;
        tick();
        rsv_en = 1'b0; lw_en = 1'b1; lw_addr = 5'd6; lw_data = 32'h66;
        tick();
        lw_en = 1'b0; rsv_en = 1'b1; rsv_addr = 5'd6;
        tick();
        rsv_en = 1'b0; rd_addr = {5'd0, 5'd6};
        tick();
        checks++; if (rd_busy[0] !== 1'b1) begin failures++; $display("FAIL coll_set_wins got=%b exp=1", rd_busy[0]); end
        lw_en = 1'b1; lw_addr = 5'd6; lw_data = 32'h67;
        tick();
        lw_en = 1'b0;
        tick();
        checks++; if (busy_any !== 1'b0) begin failures++; $display("FAIL coll_final_clear got=%b exp=0", busy_any); end
    endtask

    task automatic test_waw();
        rsv_en = 1'b1; rsv_addr = 5'd10;
        tick();
        rsv_en = 1'b0; wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h10;
        tick();
        wr_en = 1'b0;
        checks++; if (waw_err !== 1'b0) begin failures++; $display("FAIL waw_early got=%b exp=0", waw_err); end
        tick();
        checks++; if (waw_err !== 1'b1) begin failures++; $display("FAIL waw_set got=%b exp=1", waw_err); end
        lw_en = 1'b1; lw_addr = 5'd10; lw_data = 32'h1;
        tick();
        lw_en = 1'b0;
        tick(); tick();
        checks++; if (waw_err !== 1'b1) begin failures++; $display("FAIL waw_sticky got=%b exp=1", waw_err); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        checks++; if (waw_err !== 1'b0) begin failures++; $display("FAIL waw_rst got=%b exp=0", waw_err); end
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    // Architectural model: arch[] is the value a reader sees for each register
    // once the writes captured so far are applied (late first, then main, so
    // the main write wins). A paused main write is reapplied every cycle.
    task automatic test_random();
        logic [31:0] arch [32];
        bit          busy [32];
        int          ra [2];
        bit          mv, lv, werr;
        int          ma, la;
        logic [31:0] md, ld, exp_d;
        bit          exp_b, any;
        rst = 1'b1;
        tick();
        for (int k = 0; k < 32; k++) begin arch[k] = 32'd0; busy[k] = 1'b0; end
        ra[0] = 0; ra[1] = 0; mv = 1'b0; lv = 1'b0; werr = 1'b0;
        ma = 0; la = 0; md = 32'd0; ld = 32'd0;
        for (int c = 0; c < 500; c++) begin
            rst        = ($urandom_range(0, 99) == 0);
            pause      = ($urandom_range(0, 4) == 0);
            rd_clk_cls = ($urandom_range(0, 4) == 0);
            rd_addr    = {rnd_addr(), rnd_addr()};
            wr_en      = 1'($urandom_range(0, 1)); wr_addr = rnd_addr(); wr_data = $urandom;
            lw_en      = ($urandom_range(0, 2) == 0); lw_addr = rnd_addr(); lw_data = $urandom;
            rsv_en     = ($urandom_range(0, 3) == 0); rsv_addr = rnd_addr();
            if (rst) begin
                for (int k = 0; k < 32; k++) begin arch[k] = 32'd0; busy[k] = 1'b0; end
                ra[0] = 0; ra[1] = 0; mv = 1'b0; lv = 1'b0; werr = 1'b0;
            end else begin
                if (mv && busy[ma]) werr = 1'b1;
                if (lv) busy[la] = 1'b0;
                if (rsv_en && !pause && rsv_addr != 5'd0) busy[rsv_addr] = 1'b1;
                if (!pause) begin mv = wr_en; ma = int'(wr_addr); md = wr_data; end
                lv = lw_en; la = int'(lw_addr); ld = lw_data;
                if (lv) arch[la] = ld;
                if (mv) arch[ma] = md;
                if (!pause && !rd_clk_cls) begin
                    ra[0] = int'(rd_addr[4:0]); ra[1] = int'(rd_addr[9:5]);
                end
            end
            tick();
            for (int i = 0; i < 2; i++) begin
                exp_d = (ra[i] == 0) ? 32'd0 : arch[ra[i]];
                exp_b = busy[ra[i]] && !(lv && la == ra[i]);
                checks++;
                if (rd_data[i*32 +: 32] !== exp_d) begin
                    failures++; $display("FAIL rnd_data cyc=%0d port=%0d got=%h exp=%h", c, i, rd_data[i*32 +: 32], exp_d);
                end
                checks++;
                if (rd_busy[i] !== exp_b) begin
                    failures++; $display("FAIL rnd_busy cyc=%0d port=%0d got=%b exp=%b", c, i, rd_busy[i], exp_b);
                end
            end
            any = 1'b0;
            for (int k = 0; k < 32; k++) any = any | busy[k];
            checks++; if (busy_any !== any) begin failures++; $display("FAIL rnd_busy_any cyc=%0d got=%b exp=%b", c, busy_any, any); end
            checks++; if (waw_err !== werr) begin failures++; $display("FAIL rnd_waw cyc=%0d got=%b exp=%b", c, waw_err, werr); end
        end
        rst = 1'b0; pause = 1'b0; rd_clk_cls = 1'b0;
        wr_en = 1'b0; lw_en = 1'b0; rsv_en = 1'b0;
    endtask

    task automatic test_cfg2();
        int a;
        rst = 1'b1;
        tick();
        rst = 1'b0; rd_addr2 = {3'd3, 3'd2, 3'd1, 3'd0};
        tick();
        checks++; if (rd_data2 !== 64'd0) begin failures++; $display("FAIL cfg2_reset got=%h exp=0", rd_data2); end
        checks++; if (rd_busy2 !== 4'b0000) begin failures++; $display("FAIL cfg2_reset_busy got=%b exp=0000", rd_busy2); end
        a = 9;
        wr_en2 = 1'b1; wr_addr2 = a[2:0]; wr_data2 = 16'hBEEF;
        rd_addr2 = {3'd1, 3'd1, 3'd1, 3'd1};
        tick();
        wr_en2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_data2[i*16 +: 16] !== 16'hBEEF) begin failures++; $display("FAIL cfg2_wrap_fwd port=%0d got=%h exp=beef", i, rd_data2[i*16 +: 16]); end
        end
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_data2[i*16 +: 16] !== 16'hBEEF) begin failures++; $display("FAIL cfg2_wrap_bank port=%0d got=%h exp=beef", i, rd_data2[i*16 +: 16]); end
        end
        rsv_en2 = 1'b1; rsv_addr2 = 3'd5; rd_addr2 = {3'd5, 3'd5, 3'd5, 3'd5};
        tick();
        rsv_en2 = 1'b0;
        checks++; if (rd_busy2 !== 4'b1111) begin failures++; $display("FAIL cfg2_busy got=%b exp=1111", rd_busy2); end
        wr_en2 = 1'b1; wr_addr2 = 3'd5; wr_data2 = 16'h5A5A;
        tick();
        wr_en2 = 1'b0;
        checks++; if (rd_data2 !== {4{16'h5A5A}}) begin failures++; $display("FAIL cfg2_fwd got=%h exp=5a5a x4", rd_data2); end
        tick();
        checks++; if (waw_err2 !== 1'b1) begin failures++; $display("FAIL cfg2_waw got=%b exp=1", waw_err2); end
        checks++; if (busy_any2 !== 1'b1) begin failures++; $display("FAIL cfg2_busy_any got=%b exp=1", busy_any2); end
        tick();
        checks++; if (waw_err2 !== 1'b1) begin failures++; $display("FAIL cfg2_waw_sticky got=%b exp=1", waw_err2); end
    endtask

    initial begin
        test_reset();
        test_main_write();
        test_pause_hold();
        test_scoreboard();
        test_collision();
        test_waw();
        test_random();
        test_cfg2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
